fir_mac_sequencer: RTL and testbench

Control and datapath sequencer for a time-multiplexed single-MAC FIR filter. It accepts one signed sample per valid/ready handshake and stores it in an external circular sample RAM. It then steps through all taps, reading sample and coefficient memories and accumulating products, and presents the filtered result on a valid/ready output. It replaces the fully parallel tap-multiplier FIR wherever area matters more than throughput.

---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_mac.sv | 29 ++
 rtl/fir_mac_sequencer.sv | 146 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types, default sizes and the saturating narrow helper
// for the time-multiplexed FIR MAC sequencer.
package fir_pkg;

  localparam int FIR_TAPS = 20;
  localparam int FIR_AW   = 5;
  localparam int FIR_DW   = 32;
  localparam int FIR_ACCW = 64;
  // Working width of the saturation helper; accumulators up to this width
  // are sign-extended into it before clamping.
  localparam int FIR_SATW = 128;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RUN,
    DRAIN,
    OUT
  } fir_state_e;

  // Clamp a signed value into the signed range of a dw-bit result.
  function automatic logic signed [FIR_SATW-1:0] sat_narrow(
    input logic signed [FIR_SATW-1:0] v,
    input int                         dw
  );
    logic signed [FIR_SATW-1:0] mx;
    logic signed [FIR_SATW-1:0] mn;
    mx = (FIR_SATW'(1) << (dw - 1)) - FIR_SATW'(1);
    mn = ~mx;
    if (v > mx)      sat_narrow = mx;
    else if (v < mn) sat_narrow = mn;
    else             sat_narrow = v;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered signed multiply-accumulate. Full DW x DW product,
// sign-extended (or truncated) to ACCW, wrap-around accumulation.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DW   = FIR_DW,
  parameter int ACCW = FIR_ACCW
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic            clear,
  input  logic            en,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = $signed(a) * $signed(b);

  // Accumulator: clear wins over enable.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)      acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc + ACCW'(prod);
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: single-MAC FIR. Accepts one sample per handshake,
// writes it into an external circular sample RAM, walks all taps through
// one MAC and presents the result on a valid/ready output.
// Build macro FIR_SEQ_SAT_EN: saturate the accumulator into DW bits
// instead of plain truncation.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int AW   = FIR_AW,
  parameter int DW   = FIR_DW,
  parameter int ACCW = FIR_ACCW
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          smp_we,
  output logic [AW-1:0] smp_waddr,
  output logic [DW-1:0] smp_wdata,
  output logic [AW-1:0] smp_raddr,
  input  logic [DW-1:0] smp_rdata,
  output logic [AW-1:0] coef_raddr,
  input  logic [DW-1:0] coef_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
  localparam logic [AW:0]   TAPS_X = (AW + 1)'(TAPS);

  fir_state_e      state, state_nxt;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   clr_cnt;
  logic [AW-1:0]   k;
  logic            clr_go;
  logic            hs;
  logic            out_hs;
  logic            mac_en;
  logic [ACCW-1:0] acc;

  assign hs     = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign busy   = (state != IDLE);

  // Next state plus the combinational memory-port drive for this cycle.
  always_comb begin
    state_nxt  = state;
    smp_we     = 1'b0;
    smp_waddr  = wptr;
    smp_wdata  = in_data;
    smp_raddr  = '0;
    coef_raddr = '0;
    mac_en     = 1'b0;
    unique case (state)
      CLEAR: begin
        // clr_go holds off the first zero write until the first edge
        // after reset, so smp_we stays low while nRst is asserted.
        smp_we    = clr_go;
        smp_waddr = clr_cnt;
        smp_wdata = '0;
        if (clr_go && clr_cnt == LAST) state_nxt = IDLE;
      end
      IDLE: begin
        smp_we = hs;
        if (hs) state_nxt = RUN;
      end
      RUN: begin
        coef_raddr = k;
        // Newest sample sits at wptr; older ones walk backwards and wrap
        // at TAPS, which need not be a power of two.
        if (wptr >= k) smp_raddr = wptr - k;
        else           smp_raddr = AW'({1'b0, wptr} + TAPS_X - {1'b0, k});
        // Read data lags the address by one cycle, so tap 0 lands at k=1.
        mac_en = (k != '0);
        if (k == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        mac_en    = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        if (out_hs) state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // State register with registered handshake flags derived from next state.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= CLEAR;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      clr_go    <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == OUT);
      clr_go    <= (state_nxt == CLEAR);
    end
  end

  // Clear, tap and write-pointer counters.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      clr_cnt <= '0;
      k       <= '0;
      wptr    <= '0;
    end else begin
      if (state == CLEAR && clr_go)
        clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
      if (hs)
        k <= '0;
      else if (state == RUN)
        k <= (k == LAST) ? '0 : k + 1'b1;
      if (state == OUT && out_hs)
        wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
    end
  end

  fir_mac #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk   (clk),
    .nRst  (nRst),
    .clear (hs),
    .en    (mac_en),
    .a     (smp_rdata),
    .b     (coef_rdata),
    .acc   (acc)
  );

  // The accumulator only moves between accept and DRAIN, so the narrowed
  // view of it is stable for the whole OUT state.
`ifdef FIR_SEQ_SAT_EN
  assign out_data = DW'(sat_narrow(FIR_SATW'($signed(acc)), DW));
`else
  assign out_data = DW'(acc);
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed self-checking bench for fir_mac_sequencer
// with behavioural sample RAM and coefficient ROM.
module tb_fir_mac_sequencer;

  localparam int TAPS = 20;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int ACCW = 64;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          smp_we;
  logic [AW-1:0] smp_waddr;
  logic [DW-1:0] smp_wdata;
  logic [AW-1:0] smp_raddr;
  logic [DW-1:0] smp_rdata;
  logic [AW-1:0] coef_raddr;
  logic [DW-1:0] coef_rdata;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          busy;

  logic [DW-1:0] smp_mem  [0:(1<<AW)-1];
  logic [DW-1:0] coef_mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  fir_mac_sequencer #(.TAPS(TAPS), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .smp_we     (smp_we),
    .smp_waddr  (smp_waddr),
    .smp_wdata  (smp_wdata),
    .smp_raddr  (smp_raddr),
    .smp_rdata  (smp_rdata),
    .coef_raddr (coef_raddr),
    .coef_rdata (coef_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM/ROM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (smp_we) smp_mem[smp_waddr] <= smp_wdata;
    smp_rdata  <= smp_mem[smp_raddr];
    coef_rdata <= coef_mem[coef_raddr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_coefs(input int mode, input logic [DW-1:0] val);
    for (int i = 0; i < (1<<AW); i++)
      coef_mem[i] = (mode == 0) ? DW'(i + 1) : val;
  endtask

  // One sample through the block with out_ready high; returns what was seen.
  task automatic xfer(input logic [DW-1:0] d, output logic [DW-1:0] res,
                      output int lat, output logic [AW-1:0] wa,
                      output logic [AW-1:0] ra1, output bit ok);
    int n;
    ok = 1'b1; res = '0; lat = 0; wa = '0; ra1 = '0;
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin ok = 1'b0; in_valid = 1'b0; return; end
    wa = smp_waddr;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (lat == 2) ra1 = smp_raddr;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin ok = 1'b0; return; end
    res = out_data;
    @(negedge clk);
  endtask

  task automatic reset_and_clear(input string tag);
    int bad;
    in_valid = 1'b0; nRst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || smp_we !== 1'b0 || busy !== 1'b1 ||
        out_data !== '0 || smp_waddr !== '0 || smp_raddr !== '0 || coef_raddr !== '0) begin
      failures++;
      $display("FAIL %s reset_values: in_ready=%b out_valid=%b smp_we=%b busy=%b out_data=%h, need 0 0 0 1 0",
               tag, in_ready, out_valid, smp_we, busy, out_data);
    end
    nRst = 1'b1;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < TAPS; i++) begin
      if (smp_we !== 1'b1 || smp_waddr !== AW'(i) || smp_wdata !== '0 ||
          in_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s clear_sweep: %0d bad cycles, need 0", tag, bad);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || smp_we !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after_clear: in_ready=%b busy=%b smp_we=%b, need 1 0 0",
               tag, in_ready, busy, smp_we);
    end
  endtask

  task automatic test_reset();
    reset_and_clear("reset");
  endtask

  // Impulse into coefficients k+1: output n equals n+1. Assumes wptr=0 and
  // all-zero history on entry.
  task automatic test_impulse(input string tag);
    logic [DW-1:0] res;
    logic [AW-1:0] wa, ra1;
    int lat;
    bit ok;
    set_coefs(0, '0);
    for (int i = 0; i < TAPS; i++) begin
      xfer((i == 0) ? DW'(1) : DW'(0), res, lat, wa, ra1, ok);
      checks++;
      if (!ok || res !== DW'(i + 1)) begin
        failures++;
        $display("FAIL %s out[%0d]: got %0d ok=%0d, need %0d", tag, i, res, ok, i + 1);
      end
      checks++;
      if (lat !== TAPS + 2) begin
        failures++;
        $display("FAIL %s latency[%0d]: got %0d, need %0d", tag, i, lat, TAPS + 2);
      end
      checks++;
      if (wa !== AW'(i)) begin
        failures++;
        $display("FAIL %s waddr[%0d]: got %0d, need %0d", tag, i, wa, i);
      end
      checks++;
      if (ra1 !== ((i == 0) ? AW'(TAPS - 1) : AW'(i - 1))) begin
        failures++;
        $display("FAIL %s raddr_k1[%0d]: got %0d, need %0d", tag, i, ra1,
                 (i == 0) ? TAPS - 1 : i - 1);
      end
    end
  endtask

  // Running sum of ones: 1..20 then saturates at 20; wptr wraps at 20.
  task automatic test_ones();
    logic [DW-1:0] res;
    logic [AW-1:0] wa, ra1;
    int lat;
    bit ok;
    set_coefs(1, DW'(1));
    for (int i = 0; i < 25; i++) begin
      xfer(DW'(1), res, lat, wa, ra1, ok);
      checks++;
      if (!ok || res !== DW'((i < TAPS) ? i + 1 : TAPS)) begin
        failures++;
        $display("FAIL ones out[%0d]: got %0d ok=%0d, need %0d", i, res, ok,
                 (i < TAPS) ? i + 1 : TAPS);
      end
      checks++;
      if (wa !== AW'(i % TAPS)) begin
        failures++;
        $display("FAIL ones waddr[%0d]: got %0d, need %0d", i, wa, i % TAPS);
      end
    end
  endtask

  // out_ready low for 50 cycles in OUT while a new sample is offered.
  task automatic test_stall();
    logic [DW-1:0] res, held;
    logic [AW-1:0] wa, ra1;
    int lat, n, bad, hsn;
    bit ok;
    set_coefs(1, DW'(1));
    in_valid = 1'b1; in_data = DW'(1); out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (in_ready !== 1'b1 || smp_waddr !== AW'(5)) begin
      failures++;
      $display("FAIL stall accept: in_ready=%b waddr=%0d, need 1 5", in_ready, smp_waddr);
    end
    @(negedge clk);
    in_data = DW'(5);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall out_valid_timeout: got %b, need 1", out_valid);
    end
    held = out_data;
    checks++;
    if (held !== DW'(TAPS)) begin
      failures++;
      $display("FAIL stall result: got %0d, need %0d", held, TAPS);
    end
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || smp_we !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall hold: %0d bad cycles, need 0", bad);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    hsn = 0;
    repeat (4) begin
      if (out_valid && out_ready) hsn++;
      @(negedge clk);
    end
    checks++;
    if (hsn != 1) begin
      failures++;
      $display("FAIL stall handshakes: got %0d, need 1", hsn);
    end
    xfer(DW'(1), res, lat, wa, ra1, ok);
    checks++;
    if (!ok || wa !== AW'(6) || res !== DW'(TAPS)) begin
      failures++;
      $display("FAIL stall next_sample: waddr=%0d out=%0d ok=%0d, need 6 %0d", wa, res, ok, TAPS);
    end
  endtask

  // Asynchronous reset in OUT and in RUN at k=7, then a clean impulse.
  task automatic test_reset_midrun();
    int n;
    set_coefs(0, '0);
    in_valid = 1'b1; in_data = DW'(3); out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    #2 nRst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL out_reset async_drop: out_valid=%b busy=%b, need 0 1", out_valid, busy);
    end
    out_ready = 1'b1;
    reset_and_clear("after_out_reset");

    in_valid = 1'b1; in_data = DW'(9);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (coef_raddr !== AW'(7) || busy !== 1'b1) begin
      failures++;
      $display("FAIL run_reset position: coef_raddr=%0d busy=%b, need 7 1", coef_raddr, busy);
    end
    nRst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL run_reset state: out_valid=%b in_ready=%b busy=%b, need 0 0 1",
               out_valid, in_ready, busy);
    end
    reset_and_clear("after_run_reset");
    test_impulse("impulse_after_reset");
  endtask

  // Extreme operands: positive overflow, in-range negative, negative overflow.
  task automatic test_overflow();
    logic [DW-1:0] res, exp0, exp1, exp2;
    logic [AW-1:0] wa, ra1;
    int lat;
    bit ok;
`ifdef FIR_SEQ_SAT_EN
    exp0 = 32'h7FFF_FFFF;
    exp2 = 32'h8000_0000;
`else
    exp0 = 32'h0000_0001;
    exp2 = 32'h0000_0001;
`endif
    exp1 = 32'h8000_0001;
    reset_and_clear("before_overflow");
    set_coefs(1, 32'h7FFF_FFFF);
    xfer(32'h7FFF_FFFF, res, lat, wa, ra1, ok);
    checks++;
    if (!ok || res !== exp0) begin
      failures++;
      $display("FAIL overflow pos: got %h ok=%0d, need %h", res, ok, exp0);
    end
    xfer(32'h8000_0000, res, lat, wa, ra1, ok);
    checks++;
    if (!ok || res !== exp1) begin
      failures++;
      $display("FAIL overflow mixed: got %h ok=%0d, need %h", res, ok, exp1);
    end
    xfer(32'h8000_0000, res, lat, wa, ra1, ok);
    checks++;
    if (!ok || res !== exp2) begin
      failures++;
      $display("FAIL overflow neg: got %h ok=%0d, need %h", res, ok, exp2);
    end
  endtask

  initial begin
    set_coefs(0, '0);
    test_reset();
    test_impulse("impulse");
    test_ones();
    test_stall();
    test_reset_midrun();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
